// File: rtl/sync_stack_memory_if.sv
// Request/response bundle for sync_stack_memory.
// Handshake: wr/rd are single-cycle qualifiers with no ready; the requester must hold them low while busy=1.
// valid/err are one-cycle strobes one clock after the accepted request.
interface sync_stack_memory_if #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 11
);
  logic              wr;
  logic              rd;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              valid;
  logic              busy;
  logic              err;
  logic              dbg_clear;

  modport master (
    output wr, rd, addr, data_in,
    input  data_out, valid, busy, err, dbg_clear
  );

  modport slave (
    input  wr, rd, addr, data_in,
    output data_out, valid, busy, err, dbg_clear
  );
endinterface

// File: rtl/sync_stack_memory.sv
// Clocked word memory with 1-cycle read latency, post-reset clear sweep and out-of-range detection.
// Optional stored even parity per word: define SYNC_STACK_MEMORY_PARITY_EN.
module sync_stack_memory #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 11,
  parameter int DEPTH  = 2**AWIDTH
) (
  input logic                clk,
  input logic                rst_n,
  sync_stack_memory_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SYNC_STACK_MEMORY_PARITY_EN
  localparam int MW = DWIDTH + 1;
`else
  localparam int MW = DWIDTH;
`endif

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     clr_ptr, clr_ptr_next;
  logic [MW-1:0]     mem [DEPTH];

  logic              idle;
  logic              in_range;
  logic              wr_fire;
  logic              rd_fire;
  logic              oor_fire;
  logic              rd_fault;
  logic              mem_we;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     mem_waddr;
  logic [MW-1:0]     mem_wdata;
  logic [MW-1:0]     wr_word;
  logic [MW-1:0]     rd_word;
  logic [DWIDTH-1:0] rd_data;
  logic [DWIDTH-1:0] data_out_q;
  logic              valid_q;
  logic              err_q;

  assign idx      = bus.addr[IW-1:0];
  assign in_range = (32'(bus.addr) < 32'(DEPTH));
  assign idle     = (state == ST_IDLE);
  assign wr_fire  = idle && bus.wr && in_range;
  assign rd_fire  = idle && bus.rd;
  assign oor_fire = idle && (bus.wr || bus.rd) && !in_range;
  assign rd_word  = mem[idx];
  assign rd_data  = in_range ? rd_word[DWIDTH-1:0] : '0;

`ifdef SYNC_STACK_MEMORY_PARITY_EN
  // Even parity: XOR over the whole stored word (data + parity) must be 0.
  assign wr_word  = {^bus.data_in, bus.data_in};
  assign rd_fault = rd_fire && in_range && (^rd_word);
`else
  assign wr_word  = bus.data_in;
  assign rd_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    mem_we       = 1'b0;
    mem_waddr    = idx;
    mem_wdata    = wr_word;
    case (state)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr;
        mem_wdata    = '0;
        clr_ptr_next = clr_ptr + IW'(1);
        if (clr_ptr == IW'(DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        mem_we = wr_fire;
      end
    endcase
  end

  // Storage has no reset; the sweep after reset zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Reads sample mem before this edge's write lands, giving read-first on collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= rd_fire;
      err_q   <= oor_fire || rd_fault;
      if (rd_fire) begin
        data_out_q <= rd_data;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.dbg_clear = (state == ST_CLEAR);
endmodule

// File: tb/tb_sync_stack_memory.sv
// Directed bench for sync_stack_memory (AWIDTH=4, DEPTH=12): table vectors plus reset/sweep sequences.
module tb_sync_stack_memory;
  localparam int AW    = 4;
  localparam int DW    = 11;
  localparam int DEPTH = 12;
  localparam int NV    = 22;

  logic clk;
  logic rst_n;

  sync_stack_memory_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  sync_stack_memory #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          exp_valid;
    logic          exp_err;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [NV];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    bus.wr      = wr;
    bus.rd      = rd;
    bus.addr    = addr;
    bus.data_in = din;
  endtask

  task automatic count_sweep(input string name);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      tick();
      cnt++;
      check({name, " valid during sweep"}, bus.valid, 0);
      check({name, " err during sweep"}, bus.err, 0);
    end
    drive(1'b0, 1'b0, '0, '0);
    check({name, " sweep length"}, cnt, DEPTH);
  endtask

  task automatic read_expect(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp_d, input logic exp_e);
    drive(1'b0, 1'b1, addr, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check({name, " valid"}, bus.valid, 1);
    check({name, " err"}, bus.err, exp_e);
    check({name, " data"}, bus.data_out, exp_d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] par_exp_d;
    logic          par_exp_e;

    n_tests = 0;
    n_fail  = 0;

    //                wr    rd    addr   din     valid err   chk   data
    vecs[0]  = '{1'b0, 1'b1, 4'd5,  11'h000, 1'b1, 1'b0, 1'b1, 11'h000};
    vecs[1]  = '{1'b1, 1'b0, 4'd0,  11'h7FF, 1'b0, 1'b0, 1'b1, 11'h000};
    vecs[2]  = '{1'b0, 1'b1, 4'd0,  11'h000, 1'b1, 1'b0, 1'b1, 11'h7FF};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  11'h000, 1'b0, 1'b0, 1'b1, 11'h7FF};
    vecs[4]  = '{1'b1, 1'b0, 4'd1,  11'd42,  1'b0, 1'b0, 1'b1, 11'h7FF};
    vecs[5]  = '{1'b0, 1'b1, 4'd1,  11'h000, 1'b1, 1'b0, 1'b1, 11'd42};
    vecs[6]  = '{1'b1, 1'b0, 4'd3,  11'h155, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[7]  = '{1'b1, 1'b1, 4'd3,  11'h2AA, 1'b1, 1'b0, 1'b1, 11'h155};
    vecs[8]  = '{1'b0, 1'b1, 4'd3,  11'h000, 1'b1, 1'b0, 1'b1, 11'h2AA};
    vecs[9]  = '{1'b0, 1'b1, 4'd13, 11'h000, 1'b1, 1'b1, 1'b1, 11'h000};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  11'h000, 1'b0, 1'b0, 1'b1, 11'h000};
    vecs[11] = '{1'b1, 1'b0, 4'd14, 11'h001, 1'b0, 1'b1, 1'b1, 11'h000};
    vecs[12] = '{1'b0, 1'b1, 4'd14, 11'h000, 1'b1, 1'b1, 1'b1, 11'h000};
    vecs[13] = '{1'b0, 1'b1, 4'd4,  11'h000, 1'b1, 1'b0, 1'b1, 11'h000};
    vecs[14] = '{1'b0, 1'b1, 4'd0,  11'h000, 1'b1, 1'b0, 1'b1, 11'h7FF};
    vecs[15] = '{1'b0, 1'b1, 4'd1,  11'h000, 1'b1, 1'b0, 1'b1, 11'd42};
    vecs[16] = '{1'b0, 1'b1, 4'd3,  11'h000, 1'b1, 1'b0, 1'b1, 11'h2AA};
    vecs[17] = '{1'b0, 1'b1, 4'd11, 11'h000, 1'b1, 1'b0, 1'b1, 11'h000};
    vecs[18] = '{1'b1, 1'b0, 4'd11, 11'h5A5, 1'b0, 1'b0, 1'b1, 11'h000};
    vecs[19] = '{1'b0, 1'b1, 4'd11, 11'h000, 1'b1, 1'b0, 1'b1, 11'h5A5};
    vecs[20] = '{1'b0, 1'b1, 4'd12, 11'h000, 1'b1, 1'b1, 1'b1, 11'h000};
    vecs[21] = '{1'b1, 1'b0, 4'd2,  11'h003, 1'b0, 1'b1 & 1'b0, 1'b1, 11'h000};

    // Reset held two cycles, then release with requests asserted during the sweep.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("reset busy", bus.busy, 1);
    check("reset valid", bus.valid, 0);
    check("reset err", bus.err, 0);
    check("reset data_out", bus.data_out, 0);

    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'd4, 11'h7FF);
    count_sweep("sweep1");
    check("sweep1 busy after", bus.busy, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      tick();
      check($sformatf("vec%0d valid", i), bus.valid, vecs[i].exp_valid);
      check($sformatf("vec%0d err", i), bus.err, vecs[i].exp_err);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d data", i), bus.data_out, vecs[i].exp_data);
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("idle valid low", bus.valid, 0);

    // Corrupt a stored bit when parity is built in; otherwise the word reads back clean.
`ifdef SYNC_STACK_MEMORY_PARITY_EN
    dut.mem[2][0] = ~dut.mem[2][0];
    par_exp_d = 11'h002;
    par_exp_e = 1'b1;
`else
    par_exp_d = 11'h003;
    par_exp_e = 1'b0;
`endif
    read_expect("parity addr2", 4'd2, par_exp_d, par_exp_e);
    tick();
    check("parity err one cycle", bus.err, 0);

    // Reset in the middle of a sweep restarts it from index 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid-sweep busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_sweep("sweep2");
    read_expect("after sweep2 addr0", 4'd0, 11'h000, 1'b0);
    read_expect("after sweep2 addr11", 4'd11, 11'h000, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
